// File: rtl/alarm_setter_if.sv
// alarm_setter_if: button, read-back and load/display signals between the alarm editor and its neighbours.
interface alarm_setter_if #(parameter int BITS_N = 6);
   logic              btn_mode, btn_inc, btn_dec, btn_cancel, alarm_toggle;
   logic [BITS_N-1:0] alarm_hour, alarm_min;
   logic              load_value_enable, alarm_enable;
   logic [BITS_N-1:0] load_value_alarm_hour, load_value_alarm_min;
   logic [1:0]        edit_field;
   modport master (
      output btn_mode, btn_inc, btn_dec, btn_cancel, alarm_toggle, alarm_hour, alarm_min,
      input  load_value_enable, load_value_alarm_hour, load_value_alarm_min, alarm_enable, edit_field
   );
   modport slave (
      input  btn_mode, btn_inc, btn_dec, btn_cancel, alarm_toggle, alarm_hour, alarm_min,
      output load_value_enable, load_value_alarm_hour, load_value_alarm_min, alarm_enable, edit_field
   );
endinterface

// File: rtl/alarm_setter.sv
// alarm_setter: button-driven editor that loads a new alarm hour/minute into the alarm block.
module alarm_setter #(
   parameter int BITS_N      = 6,
   parameter int INIT_HOUR   = 7,
   parameter int INIT_MIN    = 0,
   parameter int TIMEOUT_CYC = 1000
) (
   input logic         clk,
   input logic         rst,
   alarm_setter_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT_CYC);
   localparam logic [1:0] IDLE = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, COMMIT = 2'd3;
   logic [1:0]        state, state_n, field, field_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [BITS_N-1:0] hour, hour_n, min, min_n, hour_up, hour_dn, min_up, min_dn;
   logic              ld, ld_n, en, en_n, any_btn, abort, step;
   // Out-of-range inputs are not clamped: inc wraps them to 0, dec just subtracts.
   assign hour_up = (hour >= BITS_N'(23)) ? '0 : hour + 1'b1;
   assign hour_dn = (hour == '0) ? BITS_N'(23) : hour - 1'b1;
   assign min_up  = (min >= BITS_N'(59)) ? '0 : min + 1'b1;
   assign min_dn  = (min == '0) ? BITS_N'(59) : min - 1'b1;
   assign any_btn = bus.btn_mode | bus.btn_inc | bus.btn_dec | bus.btn_cancel;
   assign abort   = bus.btn_cancel | (cnt == CW'(TIMEOUT_CYC - 1));
   assign step    = bus.btn_inc ^ bus.btn_dec;
   always_comb begin
      state_n = state;
      hour_n  = hour;
      min_n   = min;
      en_n    = en;
      ld_n    = 1'b0;
      cnt_n   = '0;
      case (state)
         IDLE: begin
            en_n = bus.alarm_toggle ? ~en : en;
            if (bus.btn_mode) begin
               state_n = SET_HOUR;
               hour_n  = bus.alarm_hour;
               min_n   = bus.alarm_min;
            end
         end
         SET_HOUR, SET_MIN: begin
            cnt_n = any_btn ? '0 : cnt + 1'b1;
            if (abort) begin
               state_n = IDLE;
               hour_n  = bus.alarm_hour;
               min_n   = bus.alarm_min;
            end else if (bus.btn_mode) begin
               state_n = (state == SET_HOUR) ? SET_MIN : COMMIT;
               ld_n    = (state == SET_MIN);
            end else if (step && state == SET_HOUR) begin
               hour_n = bus.btn_inc ? hour_up : hour_dn;
            end else if (step) begin
               min_n = bus.btn_inc ? min_up : min_dn;
            end
         end
         default: state_n = IDLE;
      endcase
      field_n = (state_n == SET_HOUR) ? 2'd1 : (state_n == SET_MIN) ? 2'd2 : 2'd0;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         hour  <= BITS_N'(INIT_HOUR);
         min   <= BITS_N'(INIT_MIN);
         ld    <= 1'b0;
         en    <= 1'b0;
         field <= 2'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         hour  <= hour_n;
         min   <= min_n;
         ld    <= ld_n;
         en    <= en_n;
         field <= field_n;
      end
   assign bus.load_value_enable     = ld;
   assign bus.load_value_alarm_hour = hour;
   assign bus.load_value_alarm_min  = min;
   assign bus.alarm_enable          = en;
   assign bus.edit_field            = field;
endmodule

// File: tb/tb_alarm_setter.sv
// tb_alarm_setter: directed steps with a strobe scoreboard for alarm_setter (TIMEOUT_CYC=8).
module tb_alarm_setter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   logic [11:0] sb[$];
   alarm_setter_if #(.BITS_N(6)) bus ();
   alarm_setter #(.BITS_N(6), .INIT_HOUR(7), .INIT_MIN(0), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   // b = {mode, inc, dec, cancel, toggle}, held for exactly one sampling edge
   task automatic press(input logic [4:0] b);
      {bus.btn_mode, bus.btn_inc, bus.btn_dec, bus.btn_cancel, bus.alarm_toggle} = b;
      @(posedge clk);
      #1;
      {bus.btn_mode, bus.btn_inc, bus.btn_dec, bus.btn_cancel, bus.alarm_toggle} = 5'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) press(5'b0);
   endtask
   task automatic set_alarm(input int h, input int m);
      bus.alarm_hour = 6'(h);
      bus.alarm_min  = 6'(m);
   endtask
   always @(negedge clk)
      if (bus.load_value_enable === 1'b1) begin
         if (sb.size() == 0) chk("unexpected_strobe", 1, 0);
         else begin
            logic [11:0] e;
            e = sb.pop_front();
            chk("sb_hour", int'(bus.load_value_alarm_hour), int'(e[11:6]));
            chk("sb_min", int'(bus.load_value_alarm_min), int'(e[5:0]));
         end
      end
   localparam logic [4:0] M = 5'b10000, I = 5'b01000, D = 5'b00100, C = 5'b00010, T = 5'b00001;
   initial begin
      {bus.btn_mode, bus.btn_inc, bus.btn_dec, bus.btn_cancel, bus.alarm_toggle} = 5'b0;
      set_alarm(7, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(5);
      chk("rst_ld", int'(bus.load_value_enable), 0);
      chk("rst_hour", int'(bus.load_value_alarm_hour), 7);
      chk("rst_min", int'(bus.load_value_alarm_min), 0);
      chk("rst_en", int'(bus.alarm_enable), 0);
      chk("rst_field", int'(bus.edit_field), 0);
      // full edit: hour 7 -> 10, minute 0 -> 59, then commit
      press(M);
      chk("edit_field_h", int'(bus.edit_field), 1);
      repeat (3) press(I);
      chk("hour_10", int'(bus.load_value_alarm_hour), 10);
      press(M);
      chk("edit_field_m", int'(bus.edit_field), 2);
      press(D);
      chk("min_59", int'(bus.load_value_alarm_min), 59);
      sb.push_back({6'd10, 6'd59});
      press(M);
      chk("commit_ld", int'(bus.load_value_enable), 1);
      chk("commit_field", int'(bus.edit_field), 0);
      idle(1);
      chk("commit_one_cycle", int'(bus.load_value_enable), 0);
      set_alarm(10, 59);
      idle(2);
      // wrap boundaries, simultaneous inc+dec, then discard
      set_alarm(23, 59);
      press(M);
      press(I);
      chk("hour_23_inc", int'(bus.load_value_alarm_hour), 0);
      press(D);
      chk("hour_0_dec", int'(bus.load_value_alarm_hour), 23);
      press(I | D);
      chk("hour_incdec", int'(bus.load_value_alarm_hour), 23);
      press(M);
      press(I);
      chk("min_59_inc", int'(bus.load_value_alarm_min), 0);
      press(D);
      chk("min_0_dec", int'(bus.load_value_alarm_min), 59);
      press(C);
      chk("cancel1_field", int'(bus.edit_field), 0);
      // cancel restores read-back values; inc in IDLE is ignored
      set_alarm(5, 30);
      press(M);
      press(I);
      press(I);
      chk("hour_7_edit", int'(bus.load_value_alarm_hour), 7);
      press(C | M | I);
      chk("cancel_hour", int'(bus.load_value_alarm_hour), 5);
      chk("cancel_min", int'(bus.load_value_alarm_min), 30);
      chk("cancel_field", int'(bus.edit_field), 0);
      press(I);
      chk("idle_inc_ignored", int'(bus.load_value_alarm_hour), 5);
      // timeout abort after 8 button-free cycles in an edit state
      set_alarm(12, 15);
      press(M);
      press(I);
      chk("to_hour_13", int'(bus.load_value_alarm_hour), 13);
      idle(7);
      chk("to_not_yet", int'(bus.edit_field), 1);
      idle(1);
      chk("to_abort_field", int'(bus.edit_field), 0);
      chk("to_abort_hour", int'(bus.load_value_alarm_hour), 12);
      // a button every 5 cycles keeps the edit alive
      press(M);
      for (int k = 0; k < 6; k++) begin
         idle(4);
         press(I);
      end
      chk("keepalive_field", int'(bus.edit_field), 1);
      chk("keepalive_hour", int'(bus.load_value_alarm_hour), 18);
      press(M);
      idle(4);
      chk("keepalive_min_field", int'(bus.edit_field), 2);
      press(C);
      // alarm_enable toggling, ignored while editing, reset during COMMIT
      press(T);
      chk("toggle_1", int'(bus.alarm_enable), 1);
      press(T);
      chk("toggle_0", int'(bus.alarm_enable), 0);
      press(T);
      set_alarm(3, 4);
      press(M);
      press(M);
      press(T);
      chk("toggle_in_set_min", int'(bus.alarm_enable), 1);
      chk("toggle_field", int'(bus.edit_field), 2);
      press(M);
      chk("pre_rst_ld", int'(bus.load_value_enable), 1);
      rst = 1'b1;
      #1;
      chk("rst_commit_ld", int'(bus.load_value_enable), 0);
      chk("rst_commit_hour", int'(bus.load_value_alarm_hour), 7);
      chk("rst_commit_en", int'(bus.alarm_enable), 0);
      chk("rst_commit_field", int'(bus.edit_field), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(3);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
